prog_channels_multi: RTL and testbench
======================================

# prog_channels_multi

Parametrised successor channel-FPGA configuration sequencer in the master FPGA, sitting between IPbus control and `spi_flash_intf`. Programs any masked subset of `N_CHAN` channel FPGAs, serially, from one of `2**IMG_SEL_W` bitstream images in SPI flash. Adds per-channel PROGRAM_B, image-slot addressing, INIT_B/DONE timeouts and a latched error report. Always restores the flash extended address register to 0 before finishing.

## Interface
- `N_CHAN`, 5, number of channel FPGAs
- `IMG_SEL_W`, 2, width of image-slot select
- `BASE_ADDR`, 32'h0100_0000, flash byte address of slot 0
- `IMG_STRIDE`, 32'h002E_0000, address step between slots (slot 1 = async image)
- `TPROG_CYCLES`, 16, PROGRAM_B low hold after all selected INIT_B low (≥250 ns)
- `TIMEOUT_W`, 24, width of INIT_B/DONE timeout counter; timeout = 2**TIMEOUT_W−1 cycles
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low (0 = reset)
- `prog_chan_start` in 1: level start request from IPbus
- `img_sel` in IMG_SEL_W: image slot, sampled in IDLE on start
- `chan_mask` in N_CHAN: channels to program, sampled in IDLE on start
- `c_progb` out N_CHAN: per-channel PROGRAM_B; unmasked channels held 1
- `c_clk` out 1: `~clk`
- `c_din` out 1: registered config data
- `initb`, `prog_done` in N_CHAN: from channels, asynchronous, double-flop synchronised internally
- `bitstream` in 1: serial data from flash
- `prog_chan_in_progress`, `store_flash_command`, `send_write_command`, `read_bitstream` out 1: to `spi_flash_intf`
- `wbuf_address` out 7, `flash_command` out 32, `flash_wr_nBits` out 12: to `spi_flash_intf`
- `end_write_command`, `end_bitstream` in 1: from `spi_flash_intf`
- `prog_chan_done` out 1: sequence complete (success or error)
- `prog_chan_error` out 1: sequence ended with error
- `err_code` out 3: 0 none, 1 empty mask, 2 INIT_B-low timeout, 3 INIT_B-high timeout, 4 DONE timeout
- `done_status` out N_CHAN: synchronised DONE of masked channels captured at end

## Operation
- Flash address A = BASE_ADDR + img_sel·IMG_STRIDE (32-bit, wraps mod 2^32); EAR = A[31:24]; READ command = {8'h03, A[23:0]}.
- States: IDLE → WREN1 → EAR_SET → READ_CMD → PROG_LOW → PROG_HOLD → INIT_WAIT → LOAD → DONE_WAIT → WREN2 → EAR_CLR → FINISH.
- Each WREN/EAR/READ step: one cycle `store_flash_command`=1 with command (WREN 32'h0600_0000 nBits 7; EAR {8'hC5, EAR, 16'h0} nBits 15), then hold `send_write_command`=1 until `end_write_command`, drop it same cycle as advancing. READ_CMD is store only.
- PROG_LOW: masked `c_progb`=0; wait all masked `initb_sync`=0. PROG_HOLD: count TPROG_CYCLES. INIT_WAIT: release progb; wait all masked `initb_sync`=1.
- LOAD: `read_bitstream`=1, `c_din`←`bitstream` each cycle until `end_bitstream`. Otherwise `c_din`=1.
- DONE_WAIT: wait all masked `prog_done_sync`=1; capture `done_status`.
- FINISH: `prog_chan_done`=1, `prog_chan_in_progress`=0; stay while `prog_chan_start`=1, then IDLE (clears done/error on next start).
- Empty mask at start: go directly to FINISH, err 1, no flash traffic.
- Any timeout: set error/code, release progb, go to WREN2 (EAR always restored to 0).
- Unmasked channels' initb/prog_done ignored.
- `wbuf_address` always 0.

## Timing
- Reset: all `c_progb`=1, `c_din`=0, all strobes/handshakes 0, `flash_command`/`flash_wr_nBits`/`wbuf_address`=0, done/error/`err_code`/`done_status`=0, state IDLE.
- Start sampled in IDLE; `store_flash_command` asserts 1 cycle later.
- initb/prog_done synchroniser latency 2 cycles.
- Timeout counter clears on entry to each of PROG_LOW, INIT_WAIT, DONE_WAIT; expires at all-ones.
- Reset mid-sequence: immediate return to reset values; EAR is NOT restored (software reissues start).

## Configuration
- `PROG_CHAN_TIMEOUT_EN` defined: timeout counters and err codes 2–4 present.
- Undefined: waits are unbounded; only err code 1 reachable; `TIMEOUT_W` unused.

## Structure
- Package `prog_chan_pkg`: state enum, `err_code` constants, flash opcodes (WREN, EAR write, READ) and bit-counts.
- Sub-module `flash_cmd_issue`: one store-then-send handshake to `spi_flash_intf`, reused for WREN/EAR/READ steps.

## Test plan
- Mask 5'b11111, img_sel 0: EAR cmd 32'hC501_0000, READ 32'h0300_0000, all progb pulse, done=1 error=0.
- img_sel 1: READ 32'h032E_0000; final EAR cmd 32'hC500_0000.
- Mask 5'b00100: only `c_progb[2]` toggles; other initb held 0 ignored; success.
- Mask 0: FINISH within 2 cycles, err_code=1, no `store_flash_command`.
- (EN) channel 3 prog_done stuck 0: err_code=4, `done_status`=5'b10111, EAR still cleared.
- Assert reset in LOAD: next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/prog_chan_pkg.sv
// Shared types and constants for the channel-FPGA configuration sequencer:
// FSM state encoding, error codes and SPI flash opcodes and bit counts.
package prog_chan_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WREN1,
        ST_EAR_SET,
        ST_READ_CMD,
        ST_PROG_LOW,
        ST_PROG_HOLD,
        ST_INIT_WAIT,
        ST_LOAD,
        ST_DONE_WAIT,
        ST_WREN2,
        ST_EAR_CLR,
        ST_FINISH
    } state_t;

    typedef enum logic {
        PH_STORE,
        PH_SEND
    } phase_t;

    localparam logic [2:0] ERR_NONE           = 3'd0;
    localparam logic [2:0] ERR_EMPTY_MASK     = 3'd1;
    localparam logic [2:0] ERR_INITB_LOW_TMO  = 3'd2;
    localparam logic [2:0] ERR_INITB_HIGH_TMO = 3'd3;
    localparam logic [2:0] ERR_DONE_TMO       = 3'd4;

    localparam logic [7:0] OP_WREN   = 8'h06;
    localparam logic [7:0] OP_EAR_WR = 8'hC5;
    localparam logic [7:0] OP_READ   = 8'h03;

    localparam logic [31:0] WREN_CMD = {OP_WREN, 24'h00_0000};

    localparam logic [11:0] NBITS_WREN = 12'd7;
    localparam logic [11:0] NBITS_EAR  = 12'd15;
    localparam logic [11:0] NBITS_READ = 12'd31;

    // Extended address register write: opcode, new EAR byte, padding.
    function automatic logic [31:0] ear_cmd(input logic [7:0] ear);
        return {OP_EAR_WR, ear, 16'h0000};
    endfunction

    // Read command carrying the low 24 address bits; the EAR supplies the rest.
    function automatic logic [31:0] read_cmd(input logic [23:0] addr_lo);
        return {OP_READ, addr_lo};
    endfunction

endpackage

// File: rtl/flash_cmd_issue.sv
// One store-then-send handshake towards spi_flash_intf. While 'active' is
// high the command is presented; the first cycle strobes store_flash_command,
// then (if need_send) send_write_command is held until end_write_command.
// step_done tells the caller to advance in the same cycle.
module flash_cmd_issue
    import prog_chan_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        need_send,
    input  logic [31:0] cmd,
    input  logic [11:0] nbits,
    input  logic        end_write_command,
    output logic        store_flash_command,
    output logic        send_write_command,
    output logic [31:0] flash_command,
    output logic [11:0] flash_wr_nBits,
    output logic        step_done
);

    phase_t phase;

    // Track whether the current command has been stored and is now being sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_STORE;
        end else if (!active) begin
            phase <= PH_STORE;
        end else begin
            case (phase)
                PH_STORE: if (need_send) phase <= PH_SEND;
                PH_SEND:  if (end_write_command) phase <= PH_STORE;
                default:  phase <= PH_STORE;
            endcase
        end
    end

    // Present the command and drive the strobe belonging to the current phase.
    always_comb begin
        store_flash_command = 1'b0;
        send_write_command  = 1'b0;
        flash_command       = 32'h0;
        flash_wr_nBits      = 12'h0;
        step_done           = 1'b0;
        if (active) begin
            flash_command  = cmd;
            flash_wr_nBits = nbits;
            if (phase == PH_STORE) begin
                store_flash_command = 1'b1;
                step_done           = !need_send;
            end else begin
                send_write_command = 1'b1;
                step_done          = end_write_command;
            end
        end
    end

endmodule

// File: rtl/prog_channels_multi.sv
// Channel-FPGA configuration sequencer: programs a masked set of channel FPGAs
// from one of several flash image slots, with per-channel PROGRAM_B and a
// latched error report. The flash EAR is always written back to 0 at the end.
// Optional feature macro: PROG_CHAN_TIMEOUT_EN adds INIT_B/DONE timeouts.
module prog_channels_multi
    import prog_chan_pkg::*;
#(
    parameter int          N_CHAN       = 5,
    parameter int          IMG_SEL_W    = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
    parameter logic [31:0] IMG_STRIDE   = 32'h002E_0000,
    parameter int          TPROG_CYCLES = 16,
    parameter int          TIMEOUT_W    = 24
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 prog_chan_start,
    input  logic [IMG_SEL_W-1:0] img_sel,
    input  logic [N_CHAN-1:0]    chan_mask,
    output logic [N_CHAN-1:0]    c_progb,
    output logic                 c_clk,
    output logic                 c_din,
    input  logic [N_CHAN-1:0]    initb,
    input  logic [N_CHAN-1:0]    prog_done,
    input  logic                 bitstream,
    output logic                 prog_chan_in_progress,
    output logic                 store_flash_command,
    output logic                 send_write_command,
    output logic                 read_bitstream,
    output logic [6:0]           wbuf_address,
    output logic [31:0]          flash_command,
    output logic [11:0]          flash_wr_nBits,
    input  logic                 end_write_command,
    input  logic                 end_bitstream,
    output logic                 prog_chan_done,
    output logic                 prog_chan_error,
    output logic [2:0]           err_code,
    output logic [N_CHAN-1:0]    done_status
);

    localparam int HOLD_W = $clog2(TPROG_CYCLES + 1);

    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("TIMEOUT_W must be at least 1");
    end

    state_t              state, state_next;
    logic [N_CHAN-1:0]   mask_q;
    logic [IMG_SEL_W-1:0] img_q;
    logic [N_CHAN-1:0]   initb_meta, initb_sync;
    logic [N_CHAN-1:0]   done_meta, done_sync;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [31:0]         flash_addr;

    logic                cmd_active, cmd_need_send, step_done;
    logic [31:0]         cmd_word;
    logic [11:0]         cmd_nbits;

    logic                set_err, capture_done;
    logic [2:0]          err_val;
    logic                initb_all_low, initb_all_high, done_all_high;
    logic                tmo_expired;

    assign flash_addr = BASE_ADDR + (32'(img_q) * IMG_STRIDE);

    assign initb_all_low  = ((initb_sync & mask_q) == '0);
    assign initb_all_high = ((initb_sync & mask_q) == mask_q);
    assign done_all_high  = ((done_sync & mask_q) == mask_q);

    assign c_clk                 = ~clk;
    assign wbuf_address          = 7'd0;
    assign c_progb               = (state == ST_PROG_LOW || state == ST_PROG_HOLD) ? ~mask_q : '1;
    assign read_bitstream        = (state == ST_LOAD);
    assign prog_chan_done        = (state == ST_FINISH);
    assign prog_chan_in_progress = (state != ST_IDLE) && (state != ST_FINISH);

    // Bring the asynchronous INIT_B and DONE lines into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            initb_meta <= '0;
            initb_sync <= '0;
            done_meta  <= '0;
            done_sync  <= '0;
        end else begin
            initb_meta <= initb;
            initb_sync <= initb_meta;
            done_meta  <= prog_done;
            done_sync  <= done_meta;
        end
    end

`ifdef PROG_CHAN_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    assign tmo_expired = &tmo_cnt;

    // Saturating wait counter, restarted whenever the FSM changes state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if (!tmo_expired) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

    // Select which flash command the handshake sub-block presents in each state.
    always_comb begin
        cmd_active    = 1'b0;
        cmd_need_send = 1'b1;
        cmd_word      = 32'h0;
        cmd_nbits     = 12'h0;
        case (state)
            ST_WREN1, ST_WREN2: begin
                cmd_active = 1'b1;
                cmd_word   = WREN_CMD;
                cmd_nbits  = NBITS_WREN;
            end
            ST_EAR_SET: begin
                cmd_active = 1'b1;
                cmd_word   = ear_cmd(flash_addr[31:24]);
                cmd_nbits  = NBITS_EAR;
            end
            ST_EAR_CLR: begin
                cmd_active = 1'b1;
                cmd_word   = ear_cmd(8'h00);
                cmd_nbits  = NBITS_EAR;
            end
            ST_READ_CMD: begin
                cmd_active    = 1'b1;
                cmd_need_send = 1'b0;
                cmd_word      = read_cmd(flash_addr[23:0]);
                cmd_nbits     = NBITS_READ;
            end
            default: ;
        endcase
    end

    flash_cmd_issue u_cmd_issue (
        .clk                 (clk),
        .reset               (reset),
        .active              (cmd_active),
        .need_send           (cmd_need_send),
        .cmd                 (cmd_word),
        .nbits               (cmd_nbits),
        .end_write_command   (end_write_command),
        .store_flash_command (store_flash_command),
        .send_write_command  (send_write_command),
        .flash_command       (flash_command),
        .flash_wr_nBits      (flash_wr_nBits),
        .step_done           (step_done)
    );

    // Next-state logic plus error and DONE-capture requests.
    always_comb begin
        state_next   = state;
        set_err      = 1'b0;
        err_val      = ERR_NONE;
        capture_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (prog_chan_start) begin
                    if (chan_mask == '0) begin
                        state_next = ST_FINISH;
                        set_err    = 1'b1;
                        err_val    = ERR_EMPTY_MASK;
                    end else begin
                        state_next = ST_WREN1;
                    end
                end
            end
            ST_WREN1:    if (step_done) state_next = ST_EAR_SET;
            ST_EAR_SET:  if (step_done) state_next = ST_READ_CMD;
            ST_READ_CMD: if (step_done) state_next = ST_PROG_LOW;
            ST_PROG_LOW: begin
                if (initb_all_low) begin
                    state_next = ST_PROG_HOLD;
                end else if (tmo_expired) begin
                    state_next = ST_WREN2;
                    set_err    = 1'b1;
                    err_val    = ERR_INITB_LOW_TMO;
                end
            end
            ST_PROG_HOLD: begin
                if (hold_cnt == HOLD_W'(TPROG_CYCLES - 1)) state_next = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (initb_all_high) begin
                    state_next = ST_LOAD;
                end else if (tmo_expired) begin
                    state_next = ST_WREN2;
                    set_err    = 1'b1;
                    err_val    = ERR_INITB_HIGH_TMO;
                end
            end
            ST_LOAD: if (end_bitstream) state_next = ST_DONE_WAIT;
            ST_DONE_WAIT: begin
                if (done_all_high) begin
                    state_next   = ST_WREN2;
                    capture_done = 1'b1;
                end else if (tmo_expired) begin
                    state_next   = ST_WREN2;
                    capture_done = 1'b1;
                    set_err      = 1'b1;
                    err_val      = ERR_DONE_TMO;
                end
            end
            ST_WREN2:   if (step_done) state_next = ST_EAR_CLR;
            ST_EAR_CLR: if (step_done) state_next = ST_FINISH;
            ST_FINISH:  if (!prog_chan_start) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // State register, request capture on start and the PROGRAM_B hold counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            img_q    <= '0;
            hold_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && prog_chan_start) begin
                mask_q <= chan_mask;
                img_q  <= img_sel;
            end
            if (state == ST_PROG_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Latched status report, cleared when a new sequence is requested.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prog_chan_error <= 1'b0;
            err_code        <= ERR_NONE;
            done_status     <= '0;
        end else begin
            if (set_err) begin
                prog_chan_error <= 1'b1;
                err_code        <= err_val;
            end else if (state == ST_IDLE && prog_chan_start) begin
                prog_chan_error <= 1'b0;
                err_code        <= ERR_NONE;
            end
            if (capture_done) begin
                done_status <= done_sync & mask_q;
            end else if (state == ST_IDLE && prog_chan_start) begin
                done_status <= '0;
            end
        end
    end

    // Configuration data: pass flash data through while loading, idle high otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_din <= 1'b0;
        end else if (state == ST_LOAD) begin
            c_din <= bitstream;
        end else begin
            c_din <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_channels_multi.sv
// Directed self-checking bench for prog_channels_multi. A small in-bench model
// plays the flash interface (write handshakes, bitstream) and the channel
// FPGAs (INIT_B follows PROGRAM_B, DONE after loading).
module tb_prog_channels_multi;

    localparam int N_CHAN = 5;
    localparam int IMG_SEL_W = 2;

    logic         clk;
    logic         reset;
    logic         prog_chan_start;
    logic [1:0]   img_sel;
    logic [4:0]   chan_mask;
    logic [4:0]   c_progb;
    logic         c_clk;
    logic         c_din;
    logic [4:0]   initb;
    logic [4:0]   prog_done;
    logic         bitstream;
    logic         prog_chan_in_progress;
    logic         store_flash_command;
    logic         send_write_command;
    logic         read_bitstream;
    logic [6:0]   wbuf_address;
    logic [31:0]  flash_command;
    logic [11:0]  flash_wr_nBits;
    logic         end_write_command;
    logic         end_bitstream;
    logic         prog_chan_done;
    logic         prog_chan_error;
    logic [2:0]   err_code;
    logic [4:0]   done_status;

    int checks = 0;
    int errors = 0;

    logic [31:0] cmdLog [8];
    logic [11:0] nbitsLog [8];
    int          nStores;
    int          firstStoreCyc;
    int          runCycles;
    int          dinErr;
    logic [4:0]  progbLowSeen;

    prog_channels_multi #(
        .N_CHAN       (N_CHAN),
        .IMG_SEL_W    (IMG_SEL_W),
        .BASE_ADDR    (32'h0100_0000),
        .IMG_STRIDE   (32'h002E_0000),
        .TPROG_CYCLES (16),
        .TIMEOUT_W    (6)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .prog_chan_start       (prog_chan_start),
        .img_sel               (img_sel),
        .chan_mask             (chan_mask),
        .c_progb               (c_progb),
        .c_clk                 (c_clk),
        .c_din                 (c_din),
        .initb                 (initb),
        .prog_done             (prog_done),
        .bitstream             (bitstream),
        .prog_chan_in_progress (prog_chan_in_progress),
        .store_flash_command   (store_flash_command),
        .send_write_command    (send_write_command),
        .read_bitstream        (read_bitstream),
        .wbuf_address          (wbuf_address),
        .flash_command         (flash_command),
        .flash_wr_nBits        (flash_wr_nBits),
        .end_write_command     (end_write_command),
        .end_bitstream         (end_bitstream),
        .prog_chan_done        (prog_chan_done),
        .prog_chan_error       (prog_chan_error),
        .err_code              (err_code),
        .done_status           (done_status)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Start one sequence and play flash and channels until FINISH (or until
    // LOAD is reached when stopAtLoad is set).
    task automatic applyStimulus(input logic [4:0] mask, input logic [1:0] sel,
                                 input logic forceUnmaskedLow, input logic [4:0] doneOk,
                                 input logic stopAtLoad);
        int   sendCnt;
        int   bitIdx;
        logic prevRead;
        logic prevBit;
        logic finished;
        logic [7:0] pattern;
        pattern       = 8'b1011_0010;
        sendCnt       = 0;
        bitIdx        = 0;
        prevRead      = 1'b0;
        prevBit       = 1'b0;
        finished      = 1'b0;
        nStores       = 0;
        firstStoreCyc = -1;
        runCycles     = 0;
        dinErr        = 0;
        progbLowSeen  = 5'b0;
        for (int i = 0; i < 8; i++) begin
            cmdLog[i]   = 32'h0;
            nbitsLog[i] = 12'h0;
        end
        img_sel         = sel;
        chan_mask       = mask;
        prog_done       = 5'b0;
        prog_chan_start = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            stepCycle();
            runCycles = cyc + 1;
            if (store_flash_command) begin
                if (nStores < 8) begin
                    cmdLog[nStores]   = flash_command;
                    nbitsLog[nStores] = flash_wr_nBits;
                end
                if (firstStoreCyc < 0) firstStoreCyc = cyc;
                nStores++;
            end
            progbLowSeen = progbLowSeen | ~c_progb;
            if (prevRead && (c_din !== prevBit)) dinErr++;
            if ((stopAtLoad && read_bitstream) || prog_chan_done) begin
                finished = 1'b1;
                break;
            end
            if (end_write_command) begin
                end_write_command = 1'b0;
                sendCnt = 0;
            end else if (send_write_command) begin
                sendCnt++;
                if (sendCnt >= 2) end_write_command = 1'b1;
            end
            prevRead = read_bitstream;
            if (end_bitstream) begin
                end_bitstream = 1'b0;
                prog_done = doneOk;
            end else if (read_bitstream) begin
                bitstream = pattern[bitIdx % 8];
                bitIdx++;
                if (bitIdx == 12) end_bitstream = 1'b1;
            end
            prevBit = bitstream;
            initb = (c_progb & mask) | (forceUnmaskedLow ? 5'b00000 : ~mask);
        end
        end_write_command = 1'b0;
        end_bitstream     = 1'b0;
        if (!finished) checkOutput("run_budget", 32'd1, 32'd0);
    endtask

    // Drop the start request and make sure the sequencer leaves FINISH.
    task automatic releaseStart(input string tag);
        prog_chan_start = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput(tag, {31'b0, prog_chan_done}, 32'd0);
    endtask

    initial begin
        reset             = 1'b0;
        prog_chan_start   = 1'b0;
        img_sel           = 2'd0;
        chan_mask         = 5'b0;
        initb             = 5'b11111;
        prog_done         = 5'b0;
        bitstream         = 1'b0;
        end_write_command = 1'b0;
        end_bitstream     = 1'b0;
        repeat (3) stepCycle();

        checkOutput("rst_progb",  {27'b0, c_progb}, 32'h1F);
        checkOutput("rst_din",    {31'b0, c_din}, 32'd0);
        checkOutput("rst_store",  {31'b0, store_flash_command}, 32'd0);
        checkOutput("rst_cmd",    flash_command, 32'd0);
        checkOutput("rst_busy",   {31'b0, prog_chan_in_progress}, 32'd0);
        checkOutput("rst_done",   {31'b0, prog_chan_done}, 32'd0);
        checkOutput("rst_errc",   {29'b0, err_code}, 32'd0);

        reset = 1'b1;
        repeat (2) stepCycle();

        $display("[TB] empty mask");
        applyStimulus(5'b00000, 2'd0, 1'b0, 5'b11111, 1'b0);
        checkOutput("empty_cycles", runCycles, 32'd1);
        checkOutput("empty_stores", nStores, 32'd0);
        checkOutput("empty_err",    {31'b0, prog_chan_error}, 32'd1);
        checkOutput("empty_code",   {29'b0, err_code}, 32'd1);
        checkOutput("empty_progb",  {27'b0, progbLowSeen}, 32'd0);
        releaseStart("empty_release");

        $display("[TB] all channels, slot 0");
        applyStimulus(5'b11111, 2'd0, 1'b0, 5'b11111, 1'b0);
        checkOutput("s0_first_store", firstStoreCyc, 32'd0);
        checkOutput("s0_stores",  nStores, 32'd5);
        checkOutput("s0_wren",    cmdLog[0], 32'h0600_0000);
        checkOutput("s0_wren_nb", {20'b0, nbitsLog[0]}, 32'd7);
        checkOutput("s0_ear",     cmdLog[1], 32'hC501_0000);
        checkOutput("s0_ear_nb",  {20'b0, nbitsLog[1]}, 32'd15);
        checkOutput("s0_read",    cmdLog[2], 32'h0300_0000);
        checkOutput("s0_ear_clr", cmdLog[4], 32'hC500_0000);
        checkOutput("s0_progb",   {27'b0, progbLowSeen}, 32'h1F);
        checkOutput("s0_din",     dinErr, 32'd0);
        checkOutput("s0_err",     {31'b0, prog_chan_error}, 32'd0);
        checkOutput("s0_code",    {29'b0, err_code}, 32'd0);
        checkOutput("s0_dstat",   {27'b0, done_status}, 32'h1F);
        checkOutput("s0_busy",    {31'b0, prog_chan_in_progress}, 32'd0);
        checkOutput("s0_wbuf",    {25'b0, wbuf_address}, 32'd0);
        releaseStart("s0_release");

        $display("[TB] all channels, slot 1");
        applyStimulus(5'b11111, 2'd1, 1'b0, 5'b11111, 1'b0);
        checkOutput("s1_ear",     cmdLog[1], 32'hC501_0000);
        checkOutput("s1_read",    cmdLog[2], 32'h032E_0000);
        checkOutput("s1_ear_clr", cmdLog[4], 32'hC500_0000);
        checkOutput("s1_done",    {31'b0, prog_chan_done}, 32'd1);
        releaseStart("s1_release");

        $display("[TB] single channel 2, slot 3, others INIT_B low");
        applyStimulus(5'b00100, 2'd3, 1'b1, 5'b11111, 1'b0);
        checkOutput("c2_read",  cmdLog[2], 32'h038A_0000);
        checkOutput("c2_progb", {27'b0, progbLowSeen}, 32'h04);
        checkOutput("c2_err",   {31'b0, prog_chan_error}, 32'd0);
        checkOutput("c2_dstat", {27'b0, done_status}, 32'h04);
        releaseStart("c2_release");

`ifdef PROG_CHAN_TIMEOUT_EN
        $display("[TB] channel 3 DONE stuck low");
        applyStimulus(5'b11111, 2'd0, 1'b0, 5'b10111, 1'b0);
        checkOutput("tmo_err",    {31'b0, prog_chan_error}, 32'd1);
        checkOutput("tmo_code",   {29'b0, err_code}, 32'd4);
        checkOutput("tmo_dstat",  {27'b0, done_status}, 32'h17);
        checkOutput("tmo_stores", nStores, 32'd5);
        checkOutput("tmo_ear_clr", cmdLog[4], 32'hC500_0000);
        releaseStart("tmo_release");
`endif

        $display("[TB] reset during LOAD");
        applyStimulus(5'b11111, 2'd1, 1'b0, 5'b11111, 1'b1);
        checkOutput("load_reached", {31'b0, read_bitstream}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("lrst_progb", {27'b0, c_progb}, 32'h1F);
        checkOutput("lrst_read",  {31'b0, read_bitstream}, 32'd0);
        prog_chan_start = 1'b0;
        stepCycle();
        checkOutput("lrst_din",   {31'b0, c_din}, 32'd0);
        checkOutput("lrst_busy",  {31'b0, prog_chan_in_progress}, 32'd0);
        checkOutput("lrst_done",  {31'b0, prog_chan_done}, 32'd0);
        checkOutput("lrst_store", {31'b0, store_flash_command}, 32'd0);
        checkOutput("lrst_send",  {31'b0, send_write_command}, 32'd0);
        checkOutput("lrst_cmd",   flash_command, 32'd0);
        checkOutput("lrst_nbits", {20'b0, flash_wr_nBits}, 32'd0);
        checkOutput("lrst_dstat", {27'b0, done_status}, 32'd0);
        reset = 1'b1;
        stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
